sample_alu_pipe: RTL and testbench
==================================

Name: sample_alu_pipe

Overview:
- Parametrised, pipelined successor to the flat gate/adder/DFF sample block.
- Exercises EDIF output of wide registered logic, tri-state drivers, carry chains, state-holding accumulators and valid/ready handshakes.
- Single clock domain; sits as a stand-alone top-level sample so every port maps to a pad.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, 8, width of completed-operation counter (wraps).

Ports:
- clk_c1  input  1  clock; all state on rising edge.
- rstn_i1  input  1  reset; asynchronous, active-low.
- in_valid_i1  input  1  operand/op presented.
- in_ready_o1  output  1  block accepts operand this cycle.
- op_i1  input  4  operation code (see Behaviour).
- a_i1  input  WIDTH  operand A.
- b_i1  input  WIDTH  operand B.
- out_valid_o1  output  1  result held valid.
- out_ready_i1  input  1  downstream accepts result.
- res_o1  output  WIDTH  registered result.
- carry_o1  output  1  carry (ADD/ACC) or borrow (SUB) of held result.
- zero_o1  output  1  1 when res_o1 == 0.
- oe_i1  input  1  enable for tri-state result copy.
- res_z_o1  output  WIDTH  res_o1 when oe_i1=1, else all Z (bufif1 per bit).
- op_cnt_o1  output  CNT_W  count of results consumed (out_valid & out_ready).

Behaviour:
- Reset (rstn_i1 low, async): s1_valid=0, out_valid_o1=0, res_o1=0, carry_o1=0, zero_o1=0 (a registered flag; it holds 0 during reset even though res_o1=0), accumulator=0, op_cnt_o1=0. res_z_o1 still follows oe_i1 (combinational tri-state). Reset mid-operation discards all in-flight data; no partial output after release.
- Stage 1 (capture): on in_valid_i1 & in_ready_o1, register op, a, b; set s1_valid.
- Stage 2 (compute/hold): loads when s1_valid and (!out_valid_o1 | out_ready_i1). Result, carry and zero are registered and out_valid_o1 is set. If the stage does not load but out_ready_i1=1, out_valid_o1 clears.
- in_ready_o1 = !s1_valid | stage-2 load this cycle (combinational, no bubble at full throughput).
- Latency: operand accepted at edge N gives out_valid_o1 high after edge N+1. Throughput is 1 op/cycle when out_ready_i1 is held high.
- Stall: while out_valid_o1 & !out_ready_i1, res_o1, carry_o1 and zero_o1 are stable. s1 holds one more op, then in_ready_o1=0.
- Op codes (W = WIDTH, all arithmetic unsigned, modulo 2^W):
  - 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NAND, 5 XNOR; carry=0.
  - 6 ADD: {carry,res} = a+b.
  - 7 SUB: res = a-b; carry = borrow = (a<b).
  - 8 INV: res = ~a; carry=0.
  - 9 PASS: res = a; carry=0.
  - 10 ACC: {carry,acc} = acc+a; res = new acc. The accumulator updates on stage-2 load, so back-to-back ACC ops chain correctly.
  - 11 CLRACC: acc=0, res=0, carry=0.
  - 12 ZERO: res=0. 13 ONE: res=all ones. 14-15 reserved: res=0, carry=0.
- zero_o1 is registered with res_o1 as (result==0).
- op_cnt_o1 increments on each out_valid_o1 & out_ready_i1 and wraps from 2^CNT_W-1 to 0.
- Simultaneous consume and new load in the same cycle: the new result replaces the old, the counter increments once, and out_valid_o1 stays high.

Test Plan (WIDTH=8, CNT_W=8):
- Reset, then single ADD a=0xF0 b=0x20, out_ready=1 -> out_valid one cycle after the accept edge, res=0x10, carry=1, zero=0, op_cnt=1.
- SUB a=0x05 b=0x05, then SUB a=0x03 b=0x04 -> res=0x00 zero=1 carry=0, then res=0xFF carry=1 zero=0.
- Logic sweep a=0xCA b=0x5C, ops 0-5 and 8 back-to-back -> 0x48, 0xDE, 0x96, 0x21, 0xB7, 0x69, 0x35 on consecutive cycles, in_ready always 1.
- CLRACC, then ACC a=0x80 three times back-to-back -> res 0x80 (c=0), 0x00 (c=1, zero=1), 0x80 (c=0).
- Stall: out_ready=0 for 4 cycles with 3 ops offered -> res held stable, in_ready drops after second accept; release -> all 3 results delivered in order, none lost or duplicated.
- oe_i1 toggle -> res_z=Z when 0, equals res when 1. Assert rstn low mid-stall -> out_valid, res, acc and op_cnt zero immediately (async); after 256 consumes op_cnt wraps to 0.

Source files
------------

// File: rtl/sample_alu_pipe.sv
// sample_alu_pipe: two-stage ALU pipeline with valid/ready handshakes,
// registered result/carry/zero flags, an accumulator, a wrapping
// completed-operation counter and a tri-state copy of the result.
module sample_alu_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_c1,
  input  logic             rstn_i1,
  input  logic             in_valid_i1,
  output logic             in_ready_o1,
  input  logic [3:0]       op_i1,
  input  logic [WIDTH-1:0] a_i1,
  input  logic [WIDTH-1:0] b_i1,
  output logic             out_valid_o1,
  input  logic             out_ready_i1,
  output logic [WIDTH-1:0] res_o1,
  output logic             carry_o1,
  output logic             zero_o1,
  input  logic             oe_i1,
  output wire  [WIDTH-1:0] res_z_o1,
  output logic [CNT_W-1:0] op_cnt_o1
);

  typedef enum logic [3:0] {
    OP_AND    = 4'd0,
    OP_OR     = 4'd1,
    OP_XOR    = 4'd2,
    OP_NOR    = 4'd3,
    OP_NAND   = 4'd4,
    OP_XNOR   = 4'd5,
    OP_ADD    = 4'd6,
    OP_SUB    = 4'd7,
    OP_INV    = 4'd8,
    OP_PASS   = 4'd9,
    OP_ACC    = 4'd10,
    OP_CLRACC = 4'd11,
    OP_ZERO   = 4'd12,
    OP_ONE    = 4'd13
  } op_e;

  // Stage 1 operand registers
  logic             s1_valid_q;
  op_e              s1_op_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;

  // Stage 2 result registers
  logic             out_valid_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q;

  logic             s2_load;
  logic             in_ready;
  logic             consume;
  logic [WIDTH:0]   sum;

  assign s2_load     = s1_valid_q & (~out_valid_q | out_ready_i1);
  assign in_ready    = ~s1_valid_q | s2_load;
  assign consume     = out_valid_q & out_ready_i1;

  assign in_ready_o1  = in_ready;
  assign out_valid_o1 = out_valid_q;
  assign res_o1       = res_q;
  assign carry_o1     = carry_q;
  assign zero_o1      = zero_q;
  assign op_cnt_o1    = cnt_q;

  // Per-bit tri-state copy of the held result
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tri
    bufif1 u_buf (res_z_o1[gi], res_q[gi], oe_i1);
  end

  // Stage 1: capture operands on handshake, drop when stage 2 takes them
  always_ff @(posedge clk_c1 or negedge rstn_i1) begin
    if (!rstn_i1) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_AND;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (in_valid_i1 && in_ready) begin
      s1_valid_q <= 1'b1;
      s1_op_q    <= op_e'(op_i1);
      s1_a_q     <= a_i1;
      s1_b_q     <= b_i1;
    end else if (s2_load) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Compute next result, carry/borrow, zero flag and accumulator
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    acc_d   = acc_q;
    sum     = '0;
    case (s1_op_q)
      OP_AND:  res_d = s1_a_q & s1_b_q;
      OP_OR:   res_d = s1_a_q | s1_b_q;
      OP_XOR:  res_d = s1_a_q ^ s1_b_q;
      OP_NOR:  res_d = ~(s1_a_q | s1_b_q);
      OP_NAND: res_d = ~(s1_a_q & s1_b_q);
      OP_XNOR: res_d = ~(s1_a_q ^ s1_b_q);
      OP_ADD: begin
        sum     = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
      end
      OP_SUB: begin
        res_d   = s1_a_q - s1_b_q;
        carry_d = (s1_a_q < s1_b_q);
      end
      OP_INV:  res_d = ~s1_a_q;
      OP_PASS: res_d = s1_a_q;
      OP_ACC: begin
        sum     = {1'b0, acc_q} + {1'b0, s1_a_q};
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        acc_d   = sum[WIDTH-1:0];
      end
      OP_CLRACC: acc_d = '0;
      OP_ONE:    res_d = '1;
      default:   res_d = '0;
    endcase
    zero_d = (res_d == '0);
  end

  // Stage 2: load result when free or being consumed, clear valid on drain
  always_ff @(posedge clk_c1 or negedge rstn_i1) begin
    if (!rstn_i1) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      acc_q       <= '0;
    end else if (s2_load) begin
      out_valid_q <= 1'b1;
      res_q       <= res_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      acc_q       <= acc_d;
    end else if (out_ready_i1) begin
      out_valid_q <= 1'b0;
    end
  end

  // Count consumed results, wrapping naturally
  always_ff @(posedge clk_c1 or negedge rstn_i1) begin
    if (!rstn_i1) begin
      cnt_q <= '0;
    end else if (consume) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_sample_alu_pipe.sv
// Bench for sample_alu_pipe: directed scenarios plus random traffic,
// all checked against an in-order scoreboard fed by an arithmetic model.
module tb_sample_alu_pipe;

  logic       clk;
  logic       rstn;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] res;
  logic       carry;
  logic       zero;
  logic       oe;
  tri   [7:0] res_z;
  logic [7:0] cnt;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup u_pu (res_z[g]);
  end

  sample_alu_pipe #(.WIDTH(8), .CNT_W(8)) dut (
    .clk_c1      (clk),
    .rstn_i1     (rstn),
    .in_valid_i1 (in_valid),
    .in_ready_o1 (in_ready),
    .op_i1       (op),
    .a_i1        (a),
    .b_i1        (b),
    .out_valid_o1(out_valid),
    .out_ready_i1(out_ready),
    .res_o1      (res),
    .carry_o1    (carry),
    .zero_o1     (zero),
    .oe_i1       (oe),
    .res_z_o1    (res_z),
    .op_cnt_o1   (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: {zero, carry, res} entries in issue order
  logic [9:0]  sb[$];
  int unsigned m_acc = 0;
  logic [7:0]  m_cnt = 0;
  int          n_cons = 0;

  // Last sampled values from step()
  logic       s_ov, s_ir, s_c, s_z, s_acc;
  logic [7:0] s_res, s_cnt;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_res;
  logic       prev_c, prev_z;

  function automatic logic [9:0] model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    int unsigned r = 0;
    int unsigned xa = x;
    int unsigned yb = y;
    logic c = 1'b0;
    case (o)
      4'd0:  r = xa & yb;
      4'd1:  r = xa | yb;
      4'd2:  r = xa ^ yb;
      4'd3:  r = 255 - (xa | yb);
      4'd4:  r = 255 - (xa & yb);
      4'd5:  r = 255 - (xa ^ yb);
      4'd6:  begin r = xa + yb; c = (r > 255); end
      4'd7:  begin c = (xa < yb); r = xa + 256 - yb; end
      4'd8:  r = 255 - xa;
      4'd9:  r = xa;
      4'd10: begin r = m_acc + xa; c = (r > 255); m_acc = r % 256; end
      4'd11: begin r = 0; m_acc = 0; end
      4'd13: r = 255;
      default: r = 0;
    endcase
    r = r % 256;
    return {(r == 0), c, r[7:0]};
  endfunction

  // One cycle: drive at negedge, sample 1ns later, score, wait next negedge
  task automatic step(input logic iv, input logic [3:0] o, input logic [7:0] ia,
                      input logic [7:0] ib, input logic ordy);
    logic [9:0] e;
    in_valid  = iv;
    op        = o;
    a         = ia;
    b         = ib;
    out_ready = ordy;
    #1;
    s_ov = out_valid; s_ir = in_ready; s_res = res; s_c = carry; s_z = zero; s_cnt = cnt;
    if (stall_prev) begin
      chk("stall_res", res, prev_res);
      chk("stall_carry", carry, prev_c);
      chk("stall_zero", zero, prev_z);
    end
    chk("op_cnt", cnt, m_cnt);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", out_valid, 0);
      end else begin
        e = sb.pop_front();
        chk("res", res, e[7:0]);
        chk("carry", carry, e[8]);
        chk("zero", zero, e[9]);
      end
      m_cnt = m_cnt + 8'd1;
      n_cons++;
    end
    stall_prev = out_valid && !out_ready;
    prev_res = res; prev_c = carry; prev_z = zero;
    s_acc = iv && in_ready;
    if (s_acc) sb.push_back(model(o, ia, ib));
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      step(1'b0, 4'd0, 8'd0, 8'd0, 1'b1);
    end
    chk("drain_left", sb.size(), 0);
    chk("drain_valid", out_valid, 0);
  endtask

  task automatic model_reset();
    sb.delete();
    m_acc = 0;
    m_cnt = 0;
    stall_prev = 1'b0;
  endtask

  logic [3:0] sw_ops[7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8};
  logic [7:0] sw_exp[7] = '{8'h48, 8'hDE, 8'h96, 8'h21, 8'hB7, 8'h69, 8'h35};
  logic [3:0] ac_ops[4] = '{4'd11, 4'd10, 4'd10, 4'd10};
  logic [7:0] ac_a[4]   = '{8'h00, 8'h80, 8'h80, 8'h80};
  logic [7:0] ac_res[4] = '{8'h00, 8'h80, 8'h00, 8'h80};
  logic       ac_c[4]   = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic       ac_z[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0; oe = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();

    // ADD with latency check
    step(1'b1, 4'd6, 8'hF0, 8'h20, 1'b1);
    chk("add_accept", s_ir, 1);
    step(1'b0, 4'd0, 8'd0, 8'd0, 1'b1);
    chk("lat_early", s_ov, 0);
    step(1'b0, 4'd0, 8'd0, 8'd0, 1'b1);
    chk("lat_valid", s_ov, 1);
    chk("add_res", s_res, 8'h10);
    chk("add_carry", s_c, 1);
    chk("add_zero", s_z, 0);
    step(1'b0, 4'd0, 8'd0, 8'd0, 1'b1);
    chk("add_cnt", s_cnt, 1);
    drain();

    // SUB equal then borrow
    step(1'b1, 4'd7, 8'h05, 8'h05, 1'b1);
    step(1'b1, 4'd7, 8'h03, 8'h04, 1'b1);
    step(1'b0, 4'd0, 8'd0, 8'd0, 1'b1);
    chk("sub0_res", s_res, 8'h00);
    chk("sub0_zero", s_z, 1);
    chk("sub0_carry", s_c, 0);
    step(1'b0, 4'd0, 8'd0, 8'd0, 1'b1);
    chk("sub1_res", s_res, 8'hFF);
    chk("sub1_carry", s_c, 1);
    chk("sub1_zero", s_z, 0);
    drain();

    // Logic sweep at full throughput
    for (int i = 0; i < 9; i++) begin
      if (i < 7) step(1'b1, sw_ops[i], 8'hCA, 8'h5C, 1'b1);
      else       step(1'b0, 4'd0, 8'd0, 8'd0, 1'b1);
      if (i < 7)  chk("sweep_ready", s_ir, 1);
      if (i >= 2) chk("sweep_res", s_res, sw_exp[i-2]);
    end
    drain();

    // Accumulator chaining
    for (int i = 0; i < 6; i++) begin
      if (i < 4) step(1'b1, ac_ops[i], ac_a[i], 8'd0, 1'b1);
      else       step(1'b0, 4'd0, 8'd0, 8'd0, 1'b1);
      if (i >= 2) begin
        chk("acc_res", s_res, ac_res[i-2]);
        chk("acc_carry", s_c, ac_c[i-2]);
        chk("acc_zero", s_z, ac_z[i-2]);
      end
    end
    drain();

    // Stall with three ops offered
    step(1'b1, 4'd6, 8'h01, 8'h01, 1'b0);
    chk("stall_acc1", s_ir, 1);
    step(1'b1, 4'd6, 8'h02, 8'h02, 1'b0);
    chk("stall_acc2", s_ir, 1);
    step(1'b1, 4'd6, 8'h03, 8'h03, 1'b0);
    chk("stall_block1", s_ir, 0);
    step(1'b1, 4'd6, 8'h03, 8'h03, 1'b0);
    chk("stall_block2", s_ir, 0);
    s_acc = 1'b0;
    for (int i = 0; i < 4 && !s_acc; i++) step(1'b1, 4'd6, 8'h03, 8'h03, 1'b1);
    chk("stall_third_accepted", s_acc, 1);
    drain();

    // Tri-state copy; held result is 0x06
    oe = 1'b0; #1;
    chk("res_z_off", res_z, 8'hFF);
    oe = 1'b1; #1;
    chk("res_z_on", res_z, 8'h06);
    @(negedge clk);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
           $urandom_range(0, 3) != 0);
    drain();

    // Async reset in the middle of a stall
    step(1'b1, 4'd9, 8'h11, 8'h00, 1'b0);
    step(1'b1, 4'd9, 8'h22, 8'h00, 1'b0);
    step(1'b1, 4'd9, 8'h33, 8'h00, 1'b0);
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_res", res, 0);
    chk("arst_carry", carry, 0);
    chk("arst_zero", zero, 0);
    chk("arst_cnt", cnt, 0);
    chk("arst_in_ready", in_ready, 1);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step(1'b0, 4'd0, 8'd0, 8'd0, 1'b1);
    step(1'b0, 4'd0, 8'd0, 8'd0, 1'b1);
    chk("post_rst_idle", s_ov, 0);
    step(1'b1, 4'd10, 8'h05, 8'h00, 1'b1);
    step(1'b0, 4'd0, 8'd0, 8'd0, 1'b1);
    step(1'b0, 4'd0, 8'd0, 8'd0, 1'b1);
    chk("post_rst_acc", s_res, 8'h05);
    drain();

    // Counter wrap after 256 consumes from reset
    rstn = 1'b0; #1;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    n_cons = 0;
    for (int i = 0; i < 300 && n_cons < 256; i++)
      step(n_cons + sb.size() < 256, 4'd9, 8'($urandom), 8'd0, 1'b1);
    chk("wrap_consumes", n_cons, 256);
    step(1'b0, 4'd0, 8'd0, 8'd0, 1'b1);
    chk("cnt_wrap", s_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
